// File: rtl/log_capture_pkg.sv
// log_capture_pkg: shared encodings and helpers for the debug-logger capture controller.
//   mode_t  - capture mode encodings (value 3 is reserved and handled as single fill)
//   state_t - controller FSM states
//   pack_coeff - builds one snapshot RAM word from a raw I/Q coefficient pair
package log_capture_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_CIRC   = 2'd1,
    MODE_SNAP   = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_SNAP_WAIT,
    ST_SNAP_WR,
    ST_DONE
  } state_t;

  // Sign-extend the low nb bits of v to 64 bits.
  function automatic logic [63:0] sext64(input logic [63:0] v, input int unsigned nb);
    logic [63:0] m;
    m = (64'd1 << nb) - 64'd1;
    if ((v & (64'd1 << (nb - 1))) != 64'd0) return v | ~m;
    return v & m;
  endfunction

  // Returns {sext(ci), sext(cq)} with each half nb_sample bits wide, right-aligned
  // in a 128-bit result so the caller can truncate to 2*nb_sample.
  function automatic logic [127:0] pack_coeff(input logic [63:0] ci, input logic [63:0] cq,
                                              input int unsigned nb_coeff,
                                              input int unsigned nb_sample);
    logic [127:0] m;
    m = (128'd1 << nb_sample) - 128'd1;
    return (({64'd0, sext64(ci, nb_coeff)} & m) << nb_sample) |
           ({64'd0, sext64(cq, nb_coeff)} & m);
  endfunction

endpackage

// File: rtl/log_capture_ram.sv
// log_capture_ram: simple dual-port RAM, one write port and one registered read port.
//   i_wr_en/i_wr_addr/i_wr_data - write port (no reset on storage)
//   i_rd_en/i_rd_addr           - read request; o_rd_data updates one cycle later
//   i_reset                     - clears only the read data register
module log_capture_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32768,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)      r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/log_capture_ctrl.sv
// log_capture_ctrl: capture controller for the on-chip debug logger.
// Captures one of N_CH {I,Q} channels (single fill or circular pre/post trigger)
// or periodic equalizer coefficient snapshots into a block RAM; the host reads
// the RAM back only while idle or done.
//   i_arm/i_abort/i_mode/i_ch_sel/i_post_count - capture control
//   i_ch_data/i_ch_valid/i_trigger             - sample path
//   i_coeff_I/i_coeff_Q                        - coefficient set for snapshots
//   i_rd_en/i_rd_addr -> o_rd_data/o_rd_valid  - host read, 1-cycle latency
//   o_busy/o_done/o_start_addr/o_trig_addr/o_wr_count - capture status
module log_capture_ctrl
  import log_capture_pkg::*;
#(
  parameter int NB_SAMPLE   = 16,
  parameter int N_CH        = 4,
  parameter int RAM_DEPTH   = 32768,
  parameter int N_COEFFS    = 11,
  parameter int NB_COEFF    = 8,
  parameter int SNAP_PERIOD = 250,
  localparam int ADDR_W = $clog2(RAM_DEPTH),
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_arm,
  input  logic                          i_abort,
  input  logic [1:0]                    i_mode,
  input  logic [CH_W-1:0]               i_ch_sel,
  input  logic [N_CH*2*NB_SAMPLE-1:0]   i_ch_data,
  input  logic [N_CH-1:0]               i_ch_valid,
  input  logic                          i_trigger,
  input  logic [ADDR_W-1:0]             i_post_count,
  input  logic [N_COEFFS*NB_COEFF-1:0]  i_coeff_I,
  input  logic [N_COEFFS*NB_COEFF-1:0]  i_coeff_Q,
  input  logic                          i_rd_en,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic [2*NB_SAMPLE-1:0]        o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [ADDR_W-1:0]             o_start_addr,
  output logic [ADDR_W-1:0]             o_trig_addr,
  output logic [ADDR_W:0]               o_wr_count
);

  localparam int SW    = 2*NB_SAMPLE;
  localparam int CNT_W = ADDR_W + 1;
  localparam int IDX_W = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;
  localparam int TMR_W = (SNAP_PERIOD > 1) ? $clog2(SNAP_PERIOD) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAM_DEPTH);

  state_t                      r_state, w_state_nxt;
  mode_t                       r_mode;
  logic [CH_W-1:0]             r_sel;
  logic [ADDR_W-1:0]           r_post, r_post_cnt, r_wr_ptr, r_trig_addr;
  logic [CNT_W-1:0]            r_wr_count;
  logic [TMR_W-1:0]            r_tmr;
  logic [IDX_W-1:0]            r_idx;
  logic [N_COEFFS-1:0][SW-1:0] r_coef;
  logic                        r_rd_valid;

  logic                        w_arm, w_rd_ok, w_capturing, w_smp_wr, w_wr_en;
  logic                        w_tmr_last, w_idx_last, w_snap_fits;
  logic [SW-1:0]               w_wr_data;
  logic [CNT_W-1:0]            w_cnt_inc, w_cnt_next, w_thr;
  logic [N_COEFFS-1:0][SW-1:0] w_coef;

  assign w_arm       = i_arm && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_rd_ok     = i_rd_en && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_capturing = (r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST);
  // Abort and reset cycles never touch the RAM.
  assign w_smp_wr    = !i_reset && !i_abort && w_capturing && i_ch_valid[r_sel];
  assign w_wr_en     = w_smp_wr || (!i_reset && !i_abort && r_state == ST_SNAP_WR);
  assign w_wr_data   = (r_state == ST_SNAP_WR) ? r_coef[r_idx] : i_ch_data[r_sel*SW +: SW];

  assign w_cnt_inc   = r_wr_count + CNT_W'(1);
  assign w_cnt_next  = (w_wr_en && r_wr_count != DEPTH_C) ? w_cnt_inc : r_wr_count;
  // i_post_count is ADDR_W bits, so it can never exceed RAM_DEPTH-1: the clamp is implicit.
  assign w_thr       = DEPTH_C - {1'b0, r_post};
  assign w_tmr_last  = (r_tmr == TMR_W'(SNAP_PERIOD - 1));
  assign w_idx_last  = (r_idx == IDX_W'(N_COEFFS - 1));
  assign w_snap_fits = ({1'b0, w_cnt_next} + (CNT_W+1)'(N_COEFFS)) <= (CNT_W+1)'(RAM_DEPTH);

  for (genvar k = 0; k < N_COEFFS; k++) begin : g_coef
    assign w_coef[k] = SW'(pack_coeff(64'(i_coeff_I[k*NB_COEFF +: NB_COEFF]),
                                      64'(i_coeff_Q[k*NB_COEFF +: NB_COEFF]),
                                      NB_COEFF, NB_SAMPLE));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE:
          if (i_arm) w_state_nxt = (i_mode == 2'd2) ? ST_SNAP_WAIT : ST_PRE;
        ST_PRE:
          if (w_smp_wr) begin
            if (r_mode == MODE_CIRC) begin
              if (w_cnt_next >= w_thr) w_state_nxt = ST_ARMED;
            end else if (w_cnt_inc == DEPTH_C) begin
              w_state_nxt = ST_DONE;
            end
          end
        ST_ARMED:
          if (i_trigger) w_state_nxt = (r_post == '0) ? ST_DONE : ST_POST;
        ST_POST:
          if (w_smp_wr && (r_post_cnt + ADDR_W'(1)) == r_post) w_state_nxt = ST_DONE;
        ST_SNAP_WAIT:
          if (w_tmr_last) w_state_nxt = ST_SNAP_WR;
        ST_SNAP_WR:
          if (w_idx_last) w_state_nxt = w_snap_fits ? ST_SNAP_WAIT : ST_DONE;
        default:
          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mode      <= MODE_SINGLE;
      r_sel       <= '0;
      r_post      <= '0;
      r_post_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_wr_count  <= '0;
      r_trig_addr <= '0;
      r_tmr       <= '0;
      r_idx       <= '0;
      r_coef      <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_arm && !i_abort) begin
        r_mode      <= (i_mode == 2'd1) ? MODE_CIRC : (i_mode == 2'd2) ? MODE_SNAP : MODE_SINGLE;
        r_sel       <= i_ch_sel;
        r_post      <= i_post_count;
        r_post_cnt  <= '0;
        r_wr_ptr    <= '0;
        r_wr_count  <= '0;
        r_trig_addr <= '0;
        r_tmr       <= '0;
        r_idx       <= '0;
      end else if (!i_abort) begin
        if (w_wr_en) begin
          r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
          r_wr_count <= w_cnt_next;
        end
        // Written-this-cycle address and next write address are both r_wr_ptr.
        if (r_state == ST_ARMED && i_trigger) r_trig_addr <= r_wr_ptr;
        if (r_state == ST_POST && w_smp_wr)   r_post_cnt  <= r_post_cnt + ADDR_W'(1);
        if (r_state == ST_SNAP_WAIT) begin
          r_tmr <= w_tmr_last ? '0 : r_tmr + TMR_W'(1);
          if (w_tmr_last) begin
            r_coef <= w_coef;
            r_idx  <= '0;
          end
        end
        if (r_state == ST_SNAP_WR) r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  log_capture_ram #(
    .DATA_W (SW),
    .DEPTH  (RAM_DEPTH)
  ) u_ram (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_ok),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  assign o_rd_valid   = r_rd_valid;
  assign o_busy       = w_capturing || (r_state == ST_SNAP_WAIT) || (r_state == ST_SNAP_WR);
  assign o_done       = (r_state == ST_DONE);
  // After a circular capture the write pointer sits on the oldest word.
  assign o_start_addr = (r_state == ST_DONE && r_mode == MODE_CIRC) ? r_wr_ptr : '0;
  assign o_trig_addr  = r_trig_addr;
  assign o_wr_count   = r_wr_count;

endmodule

// File: doc/log_capture_ctrl.md
Name: log_capture_ctrl

Overview:
Parametrised capture controller for the on-chip debug logger. It samples one of N_CH complex data channels, or snapshots the equalizer coefficient set, into an internal dual-port block RAM. Capture modes are single-shot fill, circular pre/post-trigger capture, and periodic coefficient snapshot. It sits between the equalizer/slicer datapath and the host read-out path; host reads are allowed only when no capture is in progress.

Parameters:
NB_SAMPLE, 16, width of each I or Q sample field; RAM word is 2*NB_SAMPLE
N_CH, 4, number of selectable input channels (>=2)
RAM_DEPTH, 32768, words of storage; must be a power of 2; ADDR_W = $clog2(RAM_DEPTH)
N_COEFFS, 11, coefficients per snapshot
NB_COEFF, 8, coefficient width (<= NB_SAMPLE)
SNAP_PERIOD, 250, clock cycles between coefficient snapshots (>= 2*N_COEFFS)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_arm  in  1  one-cycle pulse; starts a capture from IDLE or DONE
i_abort  in  1  one-cycle pulse; returns to IDLE from any state
i_mode  in  2  0=single fill, 1=circular trigger, 2=coeff snapshot, 3=reserved (treated as 0)
i_ch_sel  in  $clog2(N_CH)  selected channel; sampled on i_arm
i_ch_data  in  N_CH*2*NB_SAMPLE  channel k at [k*2*NB_SAMPLE +: 2*NB_SAMPLE], {I,Q}
i_ch_valid  in  N_CH  per-channel sample strobe (rate enable)
i_trigger  in  1  trigger event, circular mode only
i_post_count  in  ADDR_W  samples stored after the trigger; sampled on i_arm
i_coeff_I  in  N_COEFFS*NB_COEFF  coefficient k at [k*NB_COEFF +: NB_COEFF]
i_coeff_Q  in  N_COEFFS*NB_COEFF  same layout as i_coeff_I
i_rd_en  in  1  read request
i_rd_addr  in  ADDR_W  read address
o_rd_data  out  2*NB_SAMPLE  read data
o_rd_valid  out  1  read data valid
o_busy  out  1  capture in progress
o_done  out  1  capture complete; RAM contents stable
o_start_addr  out  ADDR_W  address of the oldest stored word
o_trig_addr  out  ADDR_W  address of the trigger sample
o_wr_count  out  ADDR_W+1  number of words stored

Behaviour:
- Reset: state IDLE. All outputs are 0, write pointer is 0, internal counters are 0. RAM contents are not cleared.
- States: IDLE, PRE, ARMED, POST, SNAP_WAIT, SNAP_WR, DONE. o_busy=1 in PRE, ARMED, POST, SNAP_WAIT and SNAP_WR. o_done=1 only in DONE.
- i_arm in IDLE or DONE:
  - Latches i_ch_sel, i_mode and i_post_count.
  - Clears the write pointer, o_wr_count and o_trig_addr.
  - Next state is PRE for modes 0/1/3, SNAP_WAIT for mode 2.
  - i_arm in any other state is ignored.
- i_abort has priority over all other inputs. Next state is IDLE and o_done=0. RAM is not altered.
- Sample write: a sample is written when the state is PRE, ARMED or POST and i_ch_valid[sel]=1. The word {I,Q} is written at the write pointer; the pointer increments modulo RAM_DEPTH; o_wr_count saturates at RAM_DEPTH.
- Mode 0 (and 3): stays in PRE until RAM_DEPTH words are written, then DONE. o_start_addr=0.
- Mode 1:
  - PRE -> ARMED once o_wr_count >= RAM_DEPTH - post_count. i_trigger is ignored in PRE.
  - ARMED keeps writing circularly. The first i_trigger=1 cycle records o_trig_addr = the address written that cycle if valid, else the next write address. Next state is POST.
  - POST writes post_count more samples, then DONE.
  - In DONE, o_start_addr = the write pointer (oldest word).
  - Edge cases: post_count=0 goes directly ARMED -> DONE on trigger. post_count >= RAM_DEPTH is clamped to RAM_DEPTH-1.
- Mode 2:
  - SNAP_WAIT counts SNAP_PERIOD cycles. On the last cycle it latches all N_COEFFS I/Q coefficient pairs, then moves to SNAP_WR.
  - SNAP_WR writes one word per cycle for N_COEFFS cycles. The word is {sign-extended coeff_I[k], sign-extended coeff_Q[k]}, k=0..N_COEFFS-1. It then returns to SNAP_WAIT with the counter cleared.
  - When the next snapshot would not fit, the state goes to DONE instead.
- Read port:
  - i_rd_en is honoured only in IDLE or DONE.
  - o_rd_data and o_rd_valid are registered, with exactly 1-cycle latency.
  - i_rd_en in any other state gives o_rd_valid=0 next cycle.
  - Simultaneous read and write cannot occur.
- Reset asserted mid-capture returns to IDLE on the next edge. Same-cycle i_reset wins over i_arm and i_abort.

Decomposition:
- Package log_capture_pkg holds:
  - mode encodings MODE_SINGLE, MODE_CIRC, MODE_SNAP;
  - state encodings;
  - a function to pack sign-extended coefficients.
- One sub-module: log_capture_ram, a simple dual-port RAM with one write port and a registered read port, 2*NB_SAMPLE x RAM_DEPTH, with no reset on storage.

Test Plan:
(All with RAM_DEPTH=16, N_CH=4, NB_SAMPLE=16, N_COEFFS=3, SNAP_PERIOD=8.)
1. Mode 0, ch 2, valid every other cycle, data = sample index -> DONE after 16 writes (32 cycles); reads of addresses 0..15 return 0..15 with 1-cycle latency; o_start_addr=0.
2. Mode 1, post=4, continuous valid, trigger at sample 40 -> ARMED entered after 12 writes; o_trig_addr=40 mod 16=8; DONE after samples 41..44; o_start_addr=13; reading from 13 upward wraps and returns 29..44.
3. Mode 2, coeffs I={-1,2,127}, Q={0,-128,5} -> words 0xFFFF0000, 0x0002FF80, 0x007F0005 at addresses 0..2; 5 snapshots written, DONE with o_wr_count=15.
4. i_abort during POST -> IDLE next cycle, o_busy=0, o_done=0; a following i_arm restarts with o_wr_count=0.
5. i_rd_en during PRE -> o_rd_valid stays 0; i_arm during ARMED -> ignored, latched sel/mode/post unchanged.
6. i_reset and i_arm in the same cycle mid-capture -> IDLE, all outputs 0; valid strobes for an unselected channel cause no writes.
